// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit LSU-to-16-bit async SRAM bridge.
package sram_pkg;

  localparam int SRAM_AW     = 18;
  localparam int SRAM_DW     = 16;
  localparam int ACC_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } sram_state_e;

endpackage

// File: rtl/sram_ctrl_32.sv
// Splits each 32-bit LSU read/write into two 16-bit accesses on an IS61WV25616
// async SRAM; every SRAM pin and the ack come straight from flops.
//
// state | meaning
// IDLE  | bus parked, waiting for i_wren / i_rden
// RD_LO | reading half-word 2*word   -> o_rdata[15:0]
// RD_HI | reading half-word 2*word+1 -> o_rdata[31:16]
// WR_LO | writing wdata[15:0]  with bmask[1:0]
// WR_HI | writing wdata[31:16] with bmask[3:2]
// DONE  | one-cycle ack, bus parked for turnaround
module sram_ctrl_32
  import sram_pkg::*;
#(
  parameter int ACC_CYC = ACC_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [17:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_bmask,
  input  logic               i_wren,
  input  logic               i_rden,
  output logic [31:0]        o_rdata,
  output logic               o_ack,
  output logic [SRAM_AW-1:0] o_sram_addr,
  inout  wire  [SRAM_DW-1:0] io_sram_dq,
  output logic               o_sram_ce_n,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  if (ACC_CYC < 2) begin : g_bad_acc_cyc
    $error("sram_ctrl_32: ACC_CYC must be at least 2");
  end

  localparam int               PH_W    = $clog2(ACC_CYC);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(ACC_CYC - 1);

  sram_state_e        state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [15:0]        word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         bmask_q, bmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ack_q, ack_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               ce_n_q, ce_n_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               lb_n_q, lb_n_d;
  logic               ub_n_q, ub_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic [SRAM_DW-1:0] dq_out_q, dq_out_d;

  logic phase_last;
  logic hi_d;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];
  assign phase_last      = (phase_q == PH_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      addr_q   <= '0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + PH_W'(1);
    word_d   = word_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (i_wren || i_rden) begin
          state_d = i_wren ? WR_LO : RD_LO;
          word_d  = i_addr[17:2];
          wdata_d = i_wdata;
          bmask_d = i_bmask;
        end
      end
      RD_LO: if (phase_last) begin
        state_d       = RD_HI;
        phase_d       = '0;
        rdata_d[15:0] = io_sram_dq;
      end
      RD_HI: if (phase_last) begin
        state_d        = DONE;
        phase_d        = '0;
        rdata_d[31:16] = io_sram_dq;
      end
      WR_LO: if (phase_last) begin
        state_d = WR_HI;
        phase_d = '0;
      end
      WR_HI: if (phase_last) begin
        state_d = DONE;
        phase_d = '0;
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Pin values are decoded from the next state so they land in flops
    // aligned with the state they belong to.
    hi_d     = (state_d == RD_HI) || (state_d == WR_HI);
    ack_d    = 1'b0;
    addr_d   = addr_q;
    ce_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;

    case (state_d)
      RD_LO, RD_HI: begin
        addr_d = {1'b0, word_d, hi_d};
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
      WR_LO, WR_HI: begin
        addr_d   = {1'b0, word_d, hi_d};
        ce_n_d   = 1'b0;
        // WE rises one cycle before the phase ends for address/data hold.
        we_n_d   = (phase_d == PH_LAST);
        lb_n_d   = hi_d ? ~bmask_d[2] : ~bmask_d[0];
        ub_n_d   = hi_d ? ~bmask_d[3] : ~bmask_d[1];
        dq_oe_d  = 1'b1;
        dq_out_d = hi_d ? wdata_d[31:16] : wdata_d[15:0];
      end
      DONE: ack_d = 1'b1;
      default: ;
    endcase
  end

  assign io_sram_dq  = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
  assign o_rdata     = rdata_q;
  assign o_ack       = ack_q;
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;

endmodule

// File: tb/tb_sram_ctrl_32.sv
// Directed bench for sram_ctrl_32: a per-cycle pin model from the transaction
// rules, plus an ACC_CYC=3 instance for timing of back-to-back traffic.
module tb_sram_ctrl_32;

  localparam int          A    = 2;
  localparam logic [15:0] PARK = 16'hC3A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        wren, rden;
  logic [31:0] rdata;
  logic        ack;
  logic [17:0] s_addr;
  wire  [15:0] dq;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;

  logic [17:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_bmask;
  logic        b_wren, b_rden;
  logic [31:0] b_rdata;
  logic        b_ack;
  logic [17:0] b_saddr;
  wire  [15:0] b_dq;
  logic        b_ce_n, b_we_n, b_oe_n, b_lb_n, b_ub_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_32 u_dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_wren(wren), .i_rden(rden), .o_rdata(rdata), .o_ack(ack),
    .o_sram_addr(s_addr), .io_sram_dq(dq), .o_sram_ce_n(ce_n), .o_sram_we_n(we_n),
    .o_sram_oe_n(oe_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  sram_ctrl_32 #(.ACC_CYC(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_addr(b_addr), .i_wdata(b_wdata), .i_bmask(b_bmask),
    .i_wren(b_wren), .i_rden(b_rden), .o_rdata(b_rdata), .o_ack(b_ack),
    .o_sram_addr(b_saddr), .io_sram_dq(b_dq), .o_sram_ce_n(b_ce_n), .o_sram_we_n(b_we_n),
    .o_sram_oe_n(b_oe_n), .o_sram_lb_n(b_lb_n), .o_sram_ub_n(b_ub_n)
  );

  // Behavioural SRAM plus a bench-side park pattern while nothing is selected.
  logic [15:0] smem [0:1023];
  assign dq = (!ce_n && !oe_n && we_n) ? smem[s_addr[9:0]] : 16'hzzzz;
  assign dq = (ce_n && oe_n && we_n) ? PARK : 16'hzzzz;
  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) smem[s_addr[9:0]][7:0]  = dq[7:0];
      if (!ub_n) smem[s_addr[9:0]][15:8] = dq[15:8];
    end
  end

  assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? (b_saddr[15:0] ^ 16'h5A5A) : 16'hzzzz;

  typedef struct {
    int          c;
    logic        active, ack;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  logic [31:0] rmem [0:511];
  logic [31:0] exp_rdata = '0;

  logic [17:0] cap_lo_addr, cap_hi_addr;
  logic [15:0] cap_lo_dq, cap_hi_dq;
  logic        cap_hi_lb, cap_hi_ub;
  int          cap_oe_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Expected pin trace of one transaction, cycle by cycle from acceptance.
  task automatic push_txn(input bit wr, input logic [17:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input int e0, input bit upd);
    logic [15:0] w;
    logic [31:0] word_val;
    exp_t        e;
    bit          hi;
    int          p;
    w        = a[17:2];
    word_val = rmem[w[8:0]];
    if (!wr) exp_rdata = word_val;
    for (int k = 0; k <= 2 * A; k++) begin
      e.c = e0 + k;
      e.rdata = exp_rdata;
      if (k == 2 * A) begin
        e.active = 1'b0; e.ack = 1'b1;
        e.ce_n = 1'b1; e.we_n = 1'b1; e.oe_n = 1'b1; e.lb_n = 1'b1; e.ub_n = 1'b1;
        e.addr = '0; e.dq = PARK;
      end else begin
        hi = (k >= A);
        p  = k % A;
        e.active = 1'b1; e.ack = 1'b0; e.ce_n = 1'b0;
        e.addr = {1'b0, w, hi};
        if (wr) begin
          e.oe_n = 1'b1;
          e.we_n = (p == A - 1);
          e.lb_n = ~m[hi ? 2 : 0];
          e.ub_n = ~m[hi ? 3 : 1];
          e.dq   = hi ? wd[31:16] : wd[15:0];
        end else begin
          e.oe_n = 1'b0; e.we_n = 1'b1; e.lb_n = 1'b0; e.ub_n = 1'b0;
          e.dq   = hi ? word_val[31:16] : word_val[15:0];
        end
      end
      q.push_back(e);
    end
    if (wr && upd)
      for (int b = 0; b < 4; b++)
        if (m[b]) rmem[w[8:0]][8*b +: 8] = wd[8*b +: 8];
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].c == cyc) begin
        ce = q.pop_front();
        chk("ack", {31'b0, ack}, {31'b0, ce.ack});
        chk("ce_n", {31'b0, ce_n}, {31'b0, ce.ce_n});
        chk("we_n", {31'b0, we_n}, {31'b0, ce.we_n});
        chk("oe_n", {31'b0, oe_n}, {31'b0, ce.oe_n});
        chk("dq", {16'b0, dq}, {16'b0, ce.dq});
        if (ce.active) begin
          chk("sram_addr", {14'b0, s_addr}, {14'b0, ce.addr});
          chk("lb_n", {31'b0, lb_n}, {31'b0, ce.lb_n});
          chk("ub_n", {31'b0, ub_n}, {31'b0, ce.ub_n});
        end
        if (ce.ack) chk("rdata", rdata, ce.rdata);
      end else begin
        chk("idle_ack", {31'b0, ack}, 32'd0);
        chk("idle_ce_n", {31'b0, ce_n}, 32'd1);
        chk("idle_we_n", {31'b0, we_n}, 32'd1);
        chk("idle_oe_n", {31'b0, oe_n}, 32'd1);
        chk("idle_dq", {16'b0, dq}, {16'b0, PARK});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input bit wr, input bit rd, input logic [17:0] a,
                        input logic [31:0] wd, input logic [3:0] m, input bit hold_rd);
    addr = a; wdata = wd; bmask = m; wren = wr; rden = rd;
    push_txn(wr, a, wd, m, cyc + 1, 1'b1);
    cap_oe_cnt = 0;
    step();
    for (int k = 0; k < 2 * A; k++) begin
      if (!oe_n) cap_oe_cnt++;
      if (k == 0) begin cap_lo_addr = s_addr; cap_lo_dq = dq; end
      if (k == A) begin
        cap_hi_addr = s_addr; cap_hi_dq = dq; cap_hi_lb = lb_n; cap_hi_ub = ub_n;
      end
      step();
    end
    chk("ack_at_2acc", {31'b0, ack}, 32'd1);
    wren = 1'b0;
    rden = hold_rd;
    step();
  endtask

  initial begin
    int acks [0:2];
    int nack;
    logic [5:0] we_pat;
    for (int i = 0; i < 1024; i++) smem[i] = '0;
    for (int i = 0; i < 512; i++)  rmem[i] = '0;
    rst = 1'b1; addr = '0; wdata = '0; bmask = '0; wren = 1'b0; rden = 1'b0;
    b_addr = '0; b_wdata = '0; b_bmask = '0; b_wren = 1'b0; b_rden = 1'b0;
    repeat (3) step();
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", {14'b0, s_addr}, 32'd0);
    chk("rst_ctl_n", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
    chk("rst_dq", {16'b0, dq}, {16'b0, PARK});
    rst = 1'b0;
    step();

    do_txn(1, 0, 18'h00010, 32'hDEADBEEF, 4'hF, 0);
    chk("wr_lo_addr", {14'b0, cap_lo_addr}, 32'h00008);
    chk("wr_hi_addr", {14'b0, cap_hi_addr}, 32'h00009);
    chk("wr_lo_dq", {16'b0, cap_lo_dq}, 32'hBEEF);
    chk("wr_hi_dq", {16'b0, cap_hi_dq}, 32'hDEAD);

    do_txn(0, 1, 18'h00010, 32'h0, 4'h0, 0);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_oe_cycles", cap_oe_cnt, 32'd4);

    do_txn(1, 0, 18'h00020, 32'h11223344, 4'hF, 0);
    do_txn(1, 0, 18'h00020, 32'h000000AA, 4'b0001, 0);
    chk("mask_hi_lb_n", {31'b0, cap_hi_lb}, 32'd1);
    chk("mask_hi_ub_n", {31'b0, cap_hi_ub}, 32'd1);
    do_txn(0, 1, 18'h00020, 32'h0, 4'h0, 0);
    chk("mask_readback", rdata, 32'h112233AA);

    do_txn(1, 1, 18'h00030, 32'h55667788, 4'hF, 1);
    do_txn(0, 1, 18'h00030, 32'h0, 4'h0, 0);
    chk("both_then_rd", rdata, 32'h55667788);

    do_txn(1, 1, 18'h00040, 32'hCAFEF00D, 4'b1100, 0);
    repeat (6) step();
    do_txn(0, 1, 18'h00040, 32'h0, 4'h0, 0);
    chk("both_dropped_rd", rdata, 32'hCAFE0000);

    do_txn(1, 0, 18'h00010, 32'hFFFFFFFF, 4'h0, 0);
    do_txn(0, 1, 18'h00010, 32'h0, 4'h0, 0);
    chk("mask0_readback", rdata, 32'hDEADBEEF);

    addr = 18'h00050; wdata = 32'h12345678; bmask = 4'hF; wren = 1'b1;
    push_txn(1, 18'h00050, 32'h12345678, 4'hF, cyc + 1, 1'b0);
    repeat (A + 1) step();
    chk("we_low_before_rst", {31'b0, we_n}, 32'd0);
    wren = 1'b0;
    rst  = 1'b1;
    #1;
    chk("rst_mid_we_n", {31'b0, we_n}, 32'd1);
    chk("rst_mid_ce_n", {31'b0, ce_n}, 32'd1);
    chk("rst_mid_dq", {16'b0, dq}, {16'b0, PARK});
    chk("rst_mid_rdata", rdata, 32'd0);
    q.delete();
    rmem[9'h014][15:0] = 16'h5678;
    exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_ack", {31'b0, ack}, 32'd0);
    end
    rst = 1'b0;
    step();
    do_txn(0, 1, 18'h00020, 32'h0, 4'h0, 0);
    chk("after_rst_rd", rdata, 32'h112233AA);

    // ACC_CYC=3 instance: held read request, then one write.
    b_addr = 18'h00040; b_rden = 1'b1;
    nack = 0;
    for (int n = 1; n <= 40 && nack < 3; n++) begin
      step();
      if (b_ack) begin
        acks[nack] = n;
        nack++;
        chk("b2b_rdata", b_rdata, 32'h5A7B5A7A);
      end
    end
    b_rden = 1'b0;
    chk("b2b_ack_count", nack, 32'd3);
    if (nack == 3) begin
      chk("b2b_first_ack", acks[0], 32'd7);
      chk("b2b_period_1", acks[1] - acks[0], 32'd8);
      chk("b2b_period_2", acks[2] - acks[1], 32'd8);
    end
    repeat (3) step();

    b_wdata = 32'h0BADF00D; b_bmask = 4'hF; b_wren = 1'b1;
    we_pat = '0;
    for (int n = 0; n < 6; n++) begin
      step();
      we_pat[n] = b_we_n;
      if (n == 0) chk("acc3_lb_n", {30'b0, b_lb_n, b_ub_n}, 32'd0);
    end
    chk("acc3_we_pattern", {26'b0, we_pat}, 32'b100100);
    step();
    chk("acc3_wr_ack", {31'b0, b_ack}, 32'd1);
    b_wren = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_ctrl_32.md
# sram_ctrl_32

Responder side of the LSU data-memory request interface. Accepts single 32-bit read or write requests (word address, byte mask, level-held request, one-cycle ack) and performs each one as two 16-bit accesses on an IS61WV25616 asynchronous SRAM (256K x 16, active-low controls). It sits between the LSU's `2'b10` (data-memory) region and the board SRAM pins.

## Interface
Parameters:
- `ACC_CYC`, default 2: clock cycles per 16-bit half access. Minimum 2.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous reset, active-high.
- `i_addr` in 18: byte address; bits [17:2] select the 32-bit word, bits [1:0] are ignored.
- `i_wdata` in 32: write data.
- `i_bmask` in 4: byte-lane write enables; bit n enables `i_wdata[8n+7:8n]`.
- `i_wren` in 1: write request, level-held.
- `i_rden` in 1: read request, level-held.
- `o_rdata` out 32: read data.
- `o_ack` out 1: one-cycle completion pulse.
- `o_sram_addr` out 18: SRAM half-word address.
- `io_sram_dq` inout 16: SRAM data bus.
- `o_sram_ce_n` out 1: SRAM chip enable, active-low.
- `o_sram_we_n` out 1: SRAM write enable, active-low.
- `o_sram_oe_n` out 1: SRAM output enable, active-low.
- `o_sram_lb_n` out 1: SRAM lower-byte enable, active-low.
- `o_sram_ub_n` out 1: SRAM upper-byte enable, active-low.

## Operation
- **FSM states.** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- **Phase counter.** Each LO/HI state lasts exactly `ACC_CYC` cycles. A phase counter runs 0..`ACC_CYC`-1 and is cleared on every state entry.
- **Acceptance (IDLE only).**
  - `i_wren`=1 → WR_LO. The write has priority if both requests are high.
  - else `i_rden`=1 → RD_LO.
  - On acceptance, latch `i_addr[17:2]`, `i_wdata` and `i_bmask`. Inputs are ignored outside IDLE.
- **Sequencing.** LO → HI → DONE. DONE lasts one cycle with `o_ack`=1, then returns to IDLE.
- **Addressing.**
  - LO half: `o_sram_addr` = {1'b0, word[15:0], 1'b0}.
  - HI half: `o_sram_addr` = {1'b0, word[15:0], 1'b1}.
- **Reads.**
  - `ce_n`=0, `oe_n`=0, `lb_n`=`ub_n`=0 for the whole phase; all lanes are read regardless of mask.
  - `io_sram_dq` is sampled on the last cycle of each phase.
  - LO phase loads `o_rdata[15:0]`; HI phase loads `o_rdata[31:16]`.
  - `o_rdata` is valid when `o_ack`=1 and holds until the next read overwrites it. Writes do not alter it.
- **Writes.**
  - `ce_n`=0 and `oe_n`=1 for the whole phase.
  - `io_sram_dq` is driven with the latched half (LO = [15:0], HI = [31:16]) for the whole phase.
  - `we_n`=0 on phase cycles 0..`ACC_CYC`-2, then 1 on the last cycle. This gives address/data hold margin past the WE rising edge.
  - LO phase: `lb_n` = ~bmask[0], `ub_n` = ~bmask[1]. HI phase: `lb_n` = ~bmask[2], `ub_n` = ~bmask[3].
  - Mask 4'b0000 still runs the full sequence and acks, with no bytes modified.
- **Bus control.**
  - `io_sram_dq` is driven only in WR states; it is high-Z otherwise.
  - IDLE and DONE keep `ce_n`/`we_n`/`oe_n`/`lb_n`/`ub_n` = 1, so every access boundary has at least one turnaround cycle.
- **Requester rule.** The requester drops its request in the ack cycle. A request still high in IDLE after DONE is accepted as a new transaction.

## Timing
- All SRAM-side outputs and `o_ack` are registered; no combinational path from inputs to outputs.
- The accepting edge is E0. LO covers cycles E0..E`ACC_CYC`, HI covers E`ACC_CYC`..E2·`ACC_CYC`, and `o_ack` is high between E2·`ACC_CYC` and E2·`ACC_CYC`+1.
- Latency:
  - Request-to-ack is 2·`ACC_CYC` cycles (4 at default).
  - Back-to-back throughput is one transaction per 2·`ACC_CYC`+2 cycles.
- Reset values (applied asynchronously):
  - state IDLE, phase counter 0.
  - `o_ack`=0, `o_rdata`=0, `o_sram_addr`=0.
  - all `*_n` outputs = 1, `io_sram_dq` high-Z.
- Reset mid-transaction: `we_n` rises immediately and no ack is issued. A partially written word is permitted.
- Parameter rule: `ACC_CYC` < 2 is an elaboration error.

## Structure
- Shared package `sram_pkg`:
  - `sram_state_e` enum {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE}.
  - `SRAM_AW`=18, `SRAM_DW`=16.
  - Default `ACC_CYC`.
- Single module, no sub-module. The tri-state is one continuous assign on a registered output-enable.
- The LSU instantiates this block with `i_wren`/`i_rden` gated by ~`o_ack`.

## Test plan
- Reset, then write 32'hDEADBEEF to addr 18'h00010 with mask 4'hF → `o_sram_addr` 18'h00008 then 18'h00009, `dq` 16'hBEEF then 16'hDEAD, `o_ack` high exactly at cycle 4.
- Read addr 18'h00010 after the write, with an SRAM model → `o_rdata`=32'hDEADBEEF with `o_ack`; `oe_n`=0 for 4 cycles; `dq` never driven.
- Write 32'h000000AA with mask 4'b0001 over 32'h11223344 → readback 32'h112233AA; HI phase shows `lb_n`=`ub_n`=1.
- `i_wren`=`i_rden`=1 at the same time → write performed, one ack; the read is accepted only if still asserted after DONE.
- Assert `i_rst` during WR_HI → `we_n`, `ce_n`=1 and `dq`=Z the same cycle; no ack; next request completes normally.
- `ACC_CYC`=3, back-to-back reads held high → ack every 8 cycles; `we_n` low for 2 of 3 cycles in each write phase.
